// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared branch-type, condition-code and resolve-state definitions
package mips_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_J    = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LTZ = 3'b010;
    localparam logic [2:0] CMP_GTZ = 3'b011;
    localparam logic [2:0] CMP_LEZ = 3'b100;
    localparam logic [2:0] CMP_GEZ = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_WAIT_OPND = 2'b01,
        S_REDIRECT  = 2'b10
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/branch_target_gen.sv
// rtl/branch_target_gen.sv - combinational branch/jump target and link-address adder
module branch_target_gen (
    input  logic [1:0]  br_type,
    input  logic [31:0] br_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] reg_target,
    output logic [31:0] target,
    output logic [31:0] link_addr
);
    import mips_pkg::*;

    logic [31:0] pc4;

    assign pc4       = br_pc + 32'd4;
    assign link_addr = br_pc + 32'd8;

    always_comb begin
        target = pc4;
        case (br_type)
            BR_COND: target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
            BR_J:    target = {pc4[31:28], imm26, 2'b00};
            BR_JR:   target = reg_target;
            default: target = pc4;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - ID-stage branch resolver issuing registered PC redirects to fetch
module branch_resolve #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [1:0]       br_type,
    input  logic [2:0]       br_cond,
    input  logic             br_link,
    input  logic [31:0]      br_pc,
    input  logic [15:0]      br_imm16,
    input  logic [25:0]      br_imm26,
    input  logic [31:0]      reg_target,
    input  logic             opnd_ready,
    output logic [2:0]       cmp_sel,
    input  logic             cmp_result,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             stall,
    output logic             link_valid,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_not_taken
);
    import mips_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    logic [1:0]  type_q;
    logic        link_q;
    logic [31:0] pc_q;
    logic [15:0] imm16_q;
    logic [25:0] imm26_q;

    logic [1:0]  type_eff;
    logic        link_eff;
    logic [31:0] pc_eff;
    logic [15:0] imm16_eff;
    logic [25:0] imm26_eff;
    logic [31:0] target;
    logic [31:0] link_next;
    logic        accept;
    logic        resolve;
    logic        taken;

    assign id_ready = (state == S_IDLE);
    assign stall    = (state != S_IDLE);
    assign accept   = id_ready & id_valid & (br_type != BR_NONE);
    assign resolve  = (accept | (state == S_WAIT_OPND)) & opnd_ready;

    // Resolving in the accept cycle uses the live ID fields; later cycles use the latched copy.
    always_comb begin
        type_eff  = type_q;
        link_eff  = link_q;
        pc_eff    = pc_q;
        imm16_eff = imm16_q;
        imm26_eff = imm26_q;
        if (state == S_IDLE) begin
            type_eff  = br_type;
            link_eff  = br_link;
            pc_eff    = br_pc;
            imm16_eff = br_imm16;
            imm26_eff = br_imm26;
        end
    end

    assign taken = (type_eff == BR_COND) ? cmp_result : 1'b1;

    branch_target_gen u_target_gen (
        .br_type    (type_eff),
        .br_pc      (pc_eff),
        .imm16      (imm16_eff),
        .imm26      (imm26_eff),
        .reg_target (reg_target),
        .target     (target),
        .link_addr  (link_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cmp_sel        <= CMP_EQ;
            type_q         <= BR_NONE;
            link_q         <= 1'b0;
            pc_q           <= 32'd0;
            imm16_q        <= 16'd0;
            imm26_q        <= 26'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            link_valid     <= 1'b0;
            link_addr      <= 32'd0;
            cnt_taken      <= '0;
            cnt_not_taken  <= '0;
        end else begin
            link_valid <= 1'b0;
            if (accept) begin
                type_q  <= br_type;
                link_q  <= br_link;
                pc_q    <= br_pc;
                imm16_q <= br_imm16;
                imm26_q <= br_imm26;
                cmp_sel <= br_cond;
                state   <= S_WAIT_OPND;
            end
            if (resolve) begin
                if (link_eff) begin
                    link_valid <= 1'b1;
                    link_addr  <= link_next;
                end
                if (taken) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                    cnt_taken      <= cnt_taken + CNT_ONE;
                    state          <= S_REDIRECT;
                end else begin
                    cnt_not_taken  <= cnt_not_taken + CNT_ONE;
                    state          <= S_IDLE;
                end
            end
            if ((state == S_REDIRECT) && redirect_ready) begin
                redirect_valid <= 1'b0;
                redirect_pc    <= RESET_PC;
                state          <= S_IDLE;
            end
        end
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Sequential consumer of the ID-stage comparator output. It accepts a decoded control-transfer instruction, drives the comparator condition select and samples the 1-bit result.
- It waits for forwarded operands, computes the target and issues a registered PC redirect to fetch through a valid/ready handshake.
- Sits between decode/hazard logic and the PC/fetch unit. It also provides the JAL link address and taken/not-taken statistics.

Parameters:
- CNT_W, 32, width of the taken and not-taken statistics counters (wrap-around).
- RESET_PC, 32'h0000_3000, value driven on redirect_pc while idle or in reset.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage presents a control-transfer instruction
- id_ready  out  1  block accepts the instruction this cycle
- br_type  in  2  00 none, 01 conditional, 10 J/JAL imm26, 11 JR/JALR register
- br_cond  in  3  condition code: 000 eq, 001 ne, 010 ltz, 011 gtz, 100 lez, 101 gez
- br_link  in  1  instruction writes link register (JAL/JALR/BxxAL)
- br_pc  in  32  PC of the branch instruction
- br_imm16  in  16  branch offset, in words
- br_imm26  in  26  jump index
- reg_target  in  32  forwarded rs value for JR/JALR
- opnd_ready  in  1  forwarded operands for the comparator/reg_target are valid
- cmp_sel  out  3  condition select driven to the comparator
- cmp_result  in  1  comparator output; 1 = condition true
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts the redirect
- stall  out  1  freeze IF/ID
- link_valid  out  1  one-cycle pulse; link_addr valid
- link_addr  out  32  br_pc+8
- cnt_taken  out  CNT_W  count of taken transfers
- cnt_not_taken  out  CNT_W  count of not-taken conditional branches

Behaviour:
- Reset (rst=1 at a clock edge) is synchronous and active-high:
  - State goes to S_IDLE.
  - Outputs: redirect_valid=0, redirect_pc=RESET_PC, link_valid=0, link_addr=0, stall=0, both counters=0.
  - cmp_sel is registered and resets to 3'b000.
  - Reset overrides any pending redirect or wait; the pending request is discarded with no handshake.
- States: S_IDLE, S_WAIT_OPND, S_REDIRECT.
- id_ready=1 only in S_IDLE; acceptance is id_valid & id_ready & br_type!=00. br_type=00 is ignored.
- On accept: latch br_type, br_cond, br_link, br_pc, br_imm16 and br_imm26. cmp_sel becomes the latched br_cond.
- Resolve condition: resolution happens in the accept cycle if opnd_ready=1; otherwise the block enters S_WAIT_OPND.
- S_WAIT_OPND: stall=1; resolution happens in the first cycle with opnd_ready=1. There is no timeout.
- Resolution:
  - taken = cmp_result for br_type 01; taken = 1 for br_type 10/11.
  - Target for 01: br_pc+4+(sign-extended imm16 << 2), modulo 2^32.
  - Target for 10: {pc4[31:28], imm26, 2'b00}, where pc4 = br_pc+4.
  - Target for 11: reg_target sampled in the resolve cycle.
- If taken: the next cycle has redirect_valid=1 with the target, state S_REDIRECT, stall=1, cnt_taken+1.
- If not taken: cnt_not_taken+1 and the block returns to S_IDLE with no redirect.
- Link: if br_link=1, link_valid pulses for the cycle after resolve, with link_addr=br_pc+8. This holds regardless of taken.
- S_REDIRECT handshake:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1 is sampled.
  - On that edge, redirect_valid drops and the state returns to S_IDLE.
  - With redirect_ready tied 1, redirect_valid is exactly one cycle wide.
- Latency: accept-to-redirect_valid is 1 cycle with operands ready, or 1+N cycles for N wait cycles.
- Delay slot: the instruction after the branch is already in IF. The redirect does not flush it, so there is no flush output.
- Simultaneous events:
  - A new id_valid during S_WAIT_OPND or S_REDIRECT is not accepted (id_ready=0); ID must hold it.
  - Resolve and redirect_ready cannot collide: the redirect is registered.
- Counter boundary: counters wrap from all-ones to 0.

Decomposition:
- Shared package mips_pkg holds:
  - br_type encodings BR_NONE/BR_COND/BR_J/BR_JR;
  - condition codes CMP_EQ..CMP_GEZ (the same values the comparator uses);
  - the state enum;
  - RESET_PC.
- One sub-module, branch_target_gen: a purely combinational target and link-address adder taking br_type, br_pc, imm16, imm26 and reg_target.

Test Plan:
- BEQ taken: br_type=01, br_cond=000, br_pc=0x3000, imm16=0x0004, opnd_ready=1, cmp_result=1, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x3014; cnt_taken=1.
- BNE not taken then backward branch:
  - br_pc=0x3100, cmp_result=0 -> no redirect, cnt_not_taken=1.
  - Then imm16=0xFFFE, taken -> redirect_pc=0x30FC.
- Operand wait: opnd_ready=0 for 3 cycles, JR with reg_target=0x0040_0000 -> stall=1 for 3 cycles, id_ready=0; redirect_valid appears 1 cycle after opnd_ready rises; redirect_pc=0x0040_0000.
- Backpressure: redirect_ready=0 for 4 cycles during a JAL from br_pc=0x3FFC with imm26=0x0000C10 -> redirect_pc=0x0000_3040 held stable for 5 cycles; link_valid pulses once with link_addr=0x4004; a second id_valid is not accepted until S_IDLE.
- Reset mid-operation: assert rst in S_REDIRECT -> next cycle redirect_valid=0, redirect_pc=RESET_PC, counters=0, id_ready=1.
- Counter wrap: preload via CNT_W=4 build, 16 taken branches -> cnt_taken returns to 0.
